// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: multi-channel PWM with a shared period and prescaler, and double-buffered
// registers that update at period boundaries. Define PWM_CENTER_ALIGN_EN to build the up-down mode.
module pwm_multi_gen #(
    parameter int N_CH    = 4,
    parameter int W       = 8,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 5,
    localparam int DATA_W = (W > PRESC_W) ? W : PRESC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_tick
);

    localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PRESC  = ADDR_W'(1);

    logic [W-1:0]       period_sh;
    logic [W-1:0]       period_act;
    logic [PRESC_W-1:0] presc_sh;
    logic [PRESC_W-1:0] presc_act;
    logic [W-1:0]       duty_sh  [N_CH];
    logic [W-1:0]       duty_act [N_CH];

    logic [PRESC_W-1:0] pc;
    logic [W-1:0]       cnt;
    logic [W-1:0]       cnt_next;
    logic               tick;
    logic               boundary;
    logic               boundary_q;
    logic               load_act;

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [ADDR_W-1:0] ADDR_MODE = ADDR_W'(N_CH + 2);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic mode_sh;
    logic mode_act;
    dir_t dir_q;
    dir_t dir_next;
`endif

    // Stopped: active registers track the shadows so a restart uses fresh values.
    assign load_act = !en || boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh <= '1;
            presc_sh  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i] <= '0;
            end
        end else if (wr_valid) begin
            if (wr_addr == ADDR_PERIOD) begin
                period_sh <= wr_data[W-1:0];
            end
            if (wr_addr == ADDR_PRESC) begin
                presc_sh <= wr_data[PRESC_W-1:0];
            end
            for (int i = 0; i < N_CH; i++) begin
                if (wr_addr == ADDR_W'(i + 2)) begin
                    duty_sh[i] <= wr_data[W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_act <= '1;
            presc_act  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_act[i] <= '0;
            end
        end else if (load_act) begin
            period_act <= period_sh;
            presc_act  <= presc_sh;
            for (int i = 0; i < N_CH; i++) begin
                duty_act[i] <= duty_sh[i];
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sh <= 1'b0;
        end else if (wr_valid && (wr_addr == ADDR_MODE)) begin
            mode_sh <= wr_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_act <= 1'b0;
        end else if (load_act) begin
            mode_act <= mode_sh;
        end
    end
`endif

    // Counter state register: prescaler always runs, main counter moves only on a tick.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pc  <= '0;
            cnt <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q <= DIR_UP;
`endif
        end else if (tick) begin
            pc  <= '0;
            cnt <= cnt_next;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q <= dir_next;
`endif
        end else begin
            pc <= pc + PRESC_W'(1);
        end
    end

    // Next-state logic; the up-down sequence overrides the edge-mode defaults.
    always_comb begin
        tick     = en && (pc == presc_act);
        boundary = tick && (cnt >= period_act);
        cnt_next = (cnt >= period_act) ? '0 : cnt + W'(1);
`ifdef PWM_CENTER_ALIGN_EN
        dir_next = DIR_UP;
        if (mode_act) begin
            dir_next = dir_q;
            if (period_act == '0) begin
                boundary = tick;
                cnt_next = '0;
                dir_next = DIR_UP;
            end else if ((cnt == W'(1)) && ((dir_q == DIR_DOWN) || (period_act == W'(1)))) begin
                boundary = tick;
                cnt_next = '0;
                dir_next = DIR_UP;
            end else if ((dir_q == DIR_UP) && (cnt < period_act)) begin
                boundary = 1'b0;
                cnt_next = cnt + W'(1);
            end else begin
                boundary = 1'b0;
                cnt_next = cnt - W'(1);
                dir_next = DIR_DOWN;
            end
        end
`endif
    end

    // period_tick is delayed twice so it lines up with pwm_out showing the new period's cnt = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out     <= '0;
            boundary_q  <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pwm_out[i] <= en && (cnt < duty_act[i]);
            end
            boundary_q  <= boundary;
            period_tick <= en && boundary_q;
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed self-checking bench for pwm_multi_gen (N_CH=4, W=8); the up-down scenario
// is compiled in only when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multi_gen;

    localparam int N_CH    = 4;
    localparam int W       = 8;
    localparam int PRESC_W = 8;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [N_CH-1:0]   pwm_out;
    logic              period_tick;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi_gen #(
        .N_CH(N_CH),
        .W(W),
        .PRESC_W(PRESC_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .pwm_out(pwm_out),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Program registers while stopped, idle one cycle so active copies settle, then enable.
    task automatic configure(input logic [7:0] period, input logic [7:0] presc,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        en = 1'b0;
        write_reg(5'd0, period);
        write_reg(5'd1, presc);
        write_reg(5'd2, d0);
        write_reg(5'd3, d1);
        write_reg(5'd4, d2);
        write_reg(5'd5, d3);
        step();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        en       = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 5'd2;
        wr_data  = 8'd5;
        step();
        step();
        step();
        rst      = 1'b0;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        n_checks++;
        if (pwm_out !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_pwm got=%b exp=%b", pwm_out, 4'b0000);
        end
        n_checks++;
        if (period_tick !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_tick got=%b exp=0", period_tick);
        end
        step();
        step();
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (pwm_out !== 4'b0000 || period_tick !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_override k=%0d got pwm=%b tick=%b exp pwm=0000 tick=0",
                         k, pwm_out, period_tick);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_pwm;
        logic       exp_tick;
        do_reset();
        configure(8'd9, 8'd0, 8'd5, 8'd0, 8'd10, 8'd0);
        for (int k = 0; k < 30; k++) begin
            step();
            exp_pwm    = 4'b0100;
            exp_pwm[0] = ((k % 10) < 5);
            exp_tick   = (k > 0) && ((k % 10) == 0);
            n_checks++;
            if (pwm_out !== exp_pwm) begin
                n_fail++;
                $display("[TB] FAIL basic_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
            end
            n_checks++;
            if (period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL basic_tick k=%0d got=%b exp=%b", k, period_tick, exp_tick);
            end
        end
    endtask

    task automatic test_double_buffer();
        logic [3:0] exp_pwm;
        logic       exp_tick;
        do_reset();
        configure(8'd9, 8'd0, 8'd5, 8'd0, 8'd10, 8'd0);
        for (int k = 0; k < 45; k++) begin
            step();
            exp_pwm = 4'b0100;
            if (k < 10) begin
                exp_pwm[0] = (k < 5);
            end else if (k < 30) begin
                exp_pwm[0] = ((k % 10) < 3);
            end else begin
                exp_pwm[0] = (((k - 30) % 5) < 3);
            end
            exp_tick = (k >= 10) && (((k <= 30) && ((k % 10) == 0)) ||
                                     ((k > 30) && (((k - 30) % 5) == 0)));
            n_checks++;
            if (pwm_out !== exp_pwm) begin
                n_fail++;
                $display("[TB] FAIL dbuf_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
            end
            n_checks++;
            if (period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL dbuf_tick k=%0d got=%b exp=%b", k, period_tick, exp_tick);
            end
            if (k == 3) begin
                wr_valid = 1'b1;
                wr_addr  = 5'd2;
                wr_data  = 8'd3;
            end else if (k == 18) begin
                wr_valid = 1'b1;
                wr_addr  = 5'd0;
                wr_data  = 8'd4;
            end else begin
                wr_valid = 1'b0;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_prescaler();
        logic [3:0] exp_pwm;
        logic       exp_tick;
        do_reset();
        configure(8'd3, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 30; k++) begin
            step();
            exp_pwm    = 4'b0000;
            exp_pwm[0] = ((k % 12) < 6);
            exp_tick   = (k > 0) && ((k % 12) == 0);
            n_checks++;
            if (pwm_out !== exp_pwm) begin
                n_fail++;
                $display("[TB] FAIL presc_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
            end
            n_checks++;
            if (period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL presc_tick k=%0d got=%b exp=%b", k, period_tick, exp_tick);
            end
        end
    endtask

    task automatic test_period_zero();
        logic exp_tick;
        do_reset();
        configure(8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            exp_tick = (k >= 1);
            n_checks++;
            if (pwm_out !== 4'b0001) begin
                n_fail++;
                $display("[TB] FAIL p0_pwm k=%0d got=%b exp=0001", k, pwm_out);
            end
            n_checks++;
            if (period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL p0_tick k=%0d got=%b exp=%b", k, period_tick, exp_tick);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [3:0] exp_pwm;
        logic       exp_tick;
        do_reset();
        configure(8'd9, 8'd0, 8'd5, 8'd0, 8'd10, 8'd0);
        for (int k = 0; k < 30; k++) begin
            step();
            exp_pwm    = 4'b0100;
            exp_pwm[0] = ((k % 10) < 5);
            exp_tick   = (k > 0) && ((k % 10) == 0);
            n_checks++;
            if (pwm_out !== exp_pwm || period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL unmapped k=%0d got pwm=%b tick=%b exp pwm=%b tick=%b",
                         k, pwm_out, period_tick, exp_pwm, exp_tick);
            end
            if (k == 2) begin
                wr_valid = 1'b1;
                wr_addr  = 5'd31;
                wr_data  = 8'd2;
            end else if (k == 3) begin
                wr_valid = 1'b1;
                wr_addr  = 5'd7;
                wr_data  = 8'd2;
            end else begin
                wr_valid = 1'b0;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset_mid_period();
        logic [3:0] exp_pwm;
        logic       exp_tick;
        do_reset();
        configure(8'd9, 8'd0, 8'd5, 8'd0, 8'd10, 8'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            exp_pwm = (k <= 3) ? 4'b0101 : 4'b0000;
            n_checks++;
            if (pwm_out !== exp_pwm || period_tick !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rst_mid k=%0d got pwm=%b tick=%b exp pwm=%b tick=0",
                         k, pwm_out, period_tick, exp_pwm);
            end
            rst = (k == 3);
        end
        rst = 1'b0;
        // Only duty0 is written, so period 255 and prescaler 0 must come from reset.
        en = 1'b0;
        write_reg(5'd2, 8'd200);
        step();
        en = 1'b1;
        for (int k = 0; k < 260; k++) begin
            step();
            exp_pwm    = 4'b0000;
            exp_pwm[0] = ((k % 256) < 200);
            exp_tick   = (k == 256);
            n_checks++;
            if (pwm_out !== exp_pwm || period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL rst_defaults k=%0d got pwm=%b tick=%b exp pwm=%b tick=%b",
                         k, pwm_out, period_tick, exp_pwm, exp_tick);
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] exp_pwm;
        logic       exp_tick;
        int         j;
        do_reset();
        configure(8'd9, 8'd0, 8'd5, 8'd0, 8'd10, 8'd0);
        for (int k = 0; k < 24; k++) begin
            step();
            if (k <= 6) begin
                exp_pwm    = 4'b0100;
                exp_pwm[0] = (k < 5);
                exp_tick   = 1'b0;
            end else if (k <= 11) begin
                exp_pwm  = 4'b0000;
                exp_tick = 1'b0;
            end else begin
                j          = k - 12;
                exp_pwm    = 4'b0100;
                exp_pwm[0] = ((j % 10) < 2);
                exp_tick   = (j > 0) && ((j % 10) == 0);
            end
            n_checks++;
            if (pwm_out !== exp_pwm) begin
                n_fail++;
                $display("[TB] FAIL enable_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
            end
            n_checks++;
            if (period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL enable_tick k=%0d got=%b exp=%b", k, period_tick, exp_tick);
            end
            if (k == 6) begin
                en = 1'b0;
            end
            if (k == 11) begin
                en = 1'b1;
            end
            wr_valid = (k == 8);
            wr_addr  = 5'd2;
            wr_data  = 8'd2;
        end
        wr_valid = 1'b0;
    endtask

`ifdef PWM_CENTER_ALIGN_EN
    task automatic test_center();
        logic [3:0] exp_pwm;
        logic       exp_tick;
        int         seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        do_reset();
        write_reg(5'd6, 8'd1);
        configure(8'd4, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 24; k++) begin
            step();
            exp_pwm    = 4'b0000;
            exp_pwm[0] = (seq[k % 8] < 2);
            exp_tick   = (k > 0) && ((k % 8) == 0);
            n_checks++;
            if (pwm_out !== exp_pwm) begin
                n_fail++;
                $display("[TB] FAIL center_pwm k=%0d got=%b exp=%b", k, pwm_out, exp_pwm);
            end
            n_checks++;
            if (period_tick !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL center_tick k=%0d got=%b exp=%b", k, period_tick, exp_tick);
            end
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        $display("[TB] starting pwm_multi_gen bench");
        test_reset();
        test_basic();
        test_double_buffer();
        test_prescaler();
        test_period_zero();
        test_unmapped();
        test_reset_mid_period();
        test_enable();
`ifdef PWM_CENTER_ALIGN_EN
        test_center();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
